// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: op-code width and op codes.
package logic_unit_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'b000;
    localparam logic [OP_W-1:0] OP_OR   = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XNOR = 3'b100;
    localparam logic [OP_W-1:0] OP_ANDN = 3'b101;
    localparam logic [OP_W-1:0] OP_ACCX = 3'b110;
    localparam logic [OP_W-1:0] OP_PASS = 3'b111;

endpackage

// File: rtl/logic_unit_stage.sv
// One pipeline register of the logic unit: a valid bit plus a data word,
// loaded when enabled and held otherwise so the whole pipe can stall.
module logic_unit_stage
    import logic_unit_pkg::*;
#(
    parameter int DW = 34
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          vld_in,
    input  logic [DW-1:0] d_in,
    output logic          vld_out,
    output logic [DW-1:0] d_out
);

    // Valid/data register: cleared on reset, advances on enable, holds on stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_out <= 1'b0;
            d_out   <= '0;
        end else if (en) begin
            vld_out <= vld_in;
            d_out   <= d_in;
        end
    end

endmodule

// File: rtl/pipelined_logic_unit.sv
// Pipelined 8-op bitwise logic unit with a running XOR accumulator.
// Op decode, the accumulator and the zero/parity flags are evaluated at the
// accept cycle; the result word and both flags then travel together through
// LAT hold-on-stall stages so they leave the pipe in the same cycle.
module pipelined_logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity
);

    // Carried word per stage: {parity, zero, y}.
    localparam int DW = WIDTH + 2;

    logic             stall;
    logic             accept;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] res_p0;
    logic             zero_p0;
    logic             parity_p0;

    logic [LAT:0]         vld_p;
    logic [LAT:0][DW-1:0] dat_p;

    // Bitwise op evaluation; ACCX returns the already-updated accumulator.
    function automatic logic [WIDTH-1:0] logic_op(
        input logic [OP_W-1:0]  f,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] z,
        input logic [WIDTH-1:0] acc_new
    );
        logic [WIDTH-1:0] r;
        case (f)
            OP_AND:  r = x & z;
            OP_OR:   r = x | z;
            OP_XOR:  r = x ^ z;
            OP_NOR:  r = ~(x | z);
            OP_XNOR: r = ~(x ^ z);
            OP_ANDN: r = x & ~z;
            OP_ACCX: r = acc_new;
            default: r = x;
        endcase
        return r;
    endfunction

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    // Accumulator next value: a clear on the same accept takes effect before the XOR.
    always_comb begin
        acc_base  = acc_clr ? '0 : acc;
        acc_nxt   = acc_base ^ a ^ b;
        res_p0    = logic_op(op, a, b, acc_nxt);
        zero_p0   = ~|res_p0;
        parity_p0 = ^res_p0;
    end

    // Accumulator register: changes only on an accepted ACCX or accepted clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (accept && (acc_clr || op == OP_ACCX)) begin
            acc <= (op == OP_ACCX) ? acc_nxt : '0;
        end
    end

    // Stage 0 input: accept qualifies the freshly computed result word.
    assign vld_p[0] = accept;
    assign dat_p[0] = {parity_p0, zero_p0, res_p0};

    // Register chain: every stage advances together unless the output is stalled.
    for (genvar i = 0; i < LAT; i++) begin : g_stage
        logic_unit_stage #(
            .DW(DW)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .en      (~stall),
            .vld_in  (vld_p[i]),
            .d_in    (dat_p[i]),
            .vld_out (vld_p[i+1]),
            .d_out   (dat_p[i+1])
        );
    end

    assign out_valid = vld_p[LAT];
    assign parity    = dat_p[LAT][DW-1];
    assign zero      = dat_p[LAT][DW-2];
    assign y         = dat_p[LAT][WIDTH-1:0];

endmodule
